// File: rtl/key_cmd_scheduler.sv
// key_cmd_scheduler: synchronises and debounces the active-low plus/minus keys,
// arbitrates between them and emits single-cycle cmd_up/cmd_dn pulses with
// hold-to-auto-repeat for the up/down counter datapath.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no key owns the counter, waiting for a fresh press
//   HOLD_UP | plus owns the counter, repeat timer running
//   HOLD_DN | minus owns the counter, repeat timer running
//   LOCK    | both keys involved, silent until both are released
module key_cmd_scheduler #(
    parameter int unsigned DEB_CYCLES    = 1_000_000,
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000,
    parameter int unsigned TMR_W         = 26
) (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    input  logic       key_plus,
    input  logic       key_minus,
    input  logic       repeat_en,
    output logic       cmd_up,
    output logic       cmd_dn,
    output logic [1:0] key_db,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, HOLD_UP, HOLD_DN, LOCK} state_t;

    localparam logic [TMR_W-1:0] DEB_LAST = TMR_W'(DEB_CYCLES - 1);
    localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(REPEAT_PERIOD - 1);

    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       key_db_q;
    logic [TMR_W-1:0] deb_tmr [2];
    logic [TMR_W-1:0] rpt_tmr;
    logic             rpt_first;   // first auto-repeat of this hold already due
    state_t           state;

    logic plus_fell;
    logic minus_fell;
    logic rpt_hit;

    // Bit 0 is plus, bit 1 is minus throughout, matching key_db.
    assign plus_fell  = key_db_q[0] & ~key_db[0];
    assign minus_fell = key_db_q[1] & ~key_db[1];
    assign rpt_hit    = rpt_first ? (rpt_tmr == PER_LAST) : (rpt_tmr == DLY_LAST);

    // Two-flop synchroniser for the asynchronous key pins.
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= {key_minus, key_plus};
            sync2 <= sync1;
        end
    end

    // Per-key debounce: accept a new level only after DEB_CYCLES differing samples.
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            key_db     <= 2'b11;
            key_db_q   <= 2'b11;
            deb_tmr[0] <= '0;
            deb_tmr[1] <= '0;
        end else begin
            key_db_q <= key_db;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == key_db[i]) begin
                    deb_tmr[i] <= '0;
                end else if (deb_tmr[i] == DEB_LAST) begin
                    key_db[i]  <= sync2[i];
                    deb_tmr[i] <= '0;
                end else begin
                    deb_tmr[i] <= deb_tmr[i] + TMR_W'(1);
                end
            end
        end
    end

    // Arbitration and command scheduling; busy tracks the next state.
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_up    <= 1'b0;
            cmd_dn    <= 1'b0;
            busy      <= 1'b0;
            rpt_tmr   <= '0;
            rpt_first <= 1'b0;
        end else begin
            cmd_up <= 1'b0;
            cmd_dn <= 1'b0;
            case (state)
                IDLE: begin
                    rpt_tmr   <= '0;
                    rpt_first <= 1'b0;
                    // A press while the other key is already down is a conflict too.
                    if ((plus_fell && minus_fell) ||
                        (plus_fell && !key_db[1]) || (minus_fell && !key_db[0])) begin
                        state <= LOCK;
                        busy  <= 1'b1;
                    end else if (plus_fell) begin
                        state  <= HOLD_UP;
                        cmd_up <= 1'b1;
                        busy   <= 1'b1;
                    end else if (minus_fell) begin
                        state  <= HOLD_DN;
                        cmd_dn <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                HOLD_UP: begin
                    if (key_db[0]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!key_db[1]) begin
                        state <= LOCK;
                    end else if (rpt_hit) begin
                        rpt_tmr   <= '0;
                        rpt_first <= 1'b1;
                        cmd_up    <= repeat_en;
                    end else begin
                        rpt_tmr <= rpt_tmr + TMR_W'(1);
                    end
                end
                HOLD_DN: begin
                    if (key_db[1]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!key_db[0]) begin
                        state <= LOCK;
                    end else if (rpt_hit) begin
                        rpt_tmr   <= '0;
                        rpt_first <= 1'b1;
                        cmd_dn    <= repeat_en;
                    end else begin
                        rpt_tmr <= rpt_tmr + TMR_W'(1);
                    end
                end
                LOCK: begin
                    if (key_db == 2'b11) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Testbench for key_cmd_scheduler: cycle model of the key rules compared every
// cycle, plus literal pulse-time expectations per scenario.
module tb_key_cmd_scheduler;

    localparam int DEB = 16;
    localparam int DLY = 100;
    localparam int PER = 20;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       key_plus  = 1'b1;
    logic       key_minus = 1'b1;
    logic       repeat_en = 1'b1;
    logic       cmd_up;
    logic       cmd_dn;
    logic [1:0] key_db;
    logic       busy;

    key_cmd_scheduler #(
        .DEB_CYCLES   (DEB),
        .REPEAT_DELAY (DLY),
        .REPEAT_PERIOD(PER),
        .TMR_W        (8)
    ) dut (
        .clk_50mhz(clk),
        .rst_n    (rst_n),
        .key_plus (key_plus),
        .key_minus(key_minus),
        .repeat_en(repeat_en),
        .cmd_up   (cmd_up),
        .cmd_dn   (cmd_dn),
        .key_db   (key_db),
        .busy     (busy)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;
    int up_times[$];
    int dn_times[$];
    int exp_q[$];

    // model state: mode 0 idle, 1 plus held, 2 minus held, 3 conflict
    bit [1:0] m_d1, m_d2, m_db, m_db_last, m_lvl, m_db_new;
    int       m_run[2];
    int       m_mode;
    int       m_age;
    bit       m_up, m_dn, m_busy, m_fp, m_fm;
    bit       m_valid = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc - t0, act, req);
        end
    endtask

    task automatic chk_q(input string nm, input int q[$], input int e[$]);
        chk({nm, "_count"}, q.size(), e.size());
        for (int i = 0; i < e.size() && i < q.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), q[i], e[i]);
    endtask

    function automatic bit is_rep(input int a);
        return (a == DLY) || (a > DLY && ((a - DLY) % PER) == 0);
    endfunction

    // Behavioural model: keys delayed two samples, accepted after DEB differing
    // samples, commands from press edges and hold age since the first command.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_d1 = 2'b11; m_d2 = 2'b11; m_db = 2'b11; m_db_last = 2'b11;
            m_run[0] = 0; m_run[1] = 0;
            m_mode = 0; m_age = 0;
            m_up = 1'b0; m_dn = 1'b0; m_busy = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_fp = m_db_last[0] && !m_db[0];
            m_fm = m_db_last[1] && !m_db[1];
            m_up = 1'b0;
            m_dn = 1'b0;
            case (m_mode)
                0: begin
                    if (m_fp && m_fm) m_mode = 3;
                    else if (m_fp) begin
                        if (!m_db[1]) m_mode = 3;
                        else begin m_mode = 1; m_up = 1'b1; m_age = 0; end
                    end else if (m_fm) begin
                        if (!m_db[0]) m_mode = 3;
                        else begin m_mode = 2; m_dn = 1'b1; m_age = 0; end
                    end
                end
                1: begin
                    if (m_db[0]) m_mode = 0;
                    else if (!m_db[1]) m_mode = 3;
                    else begin m_age++; if (is_rep(m_age)) m_up = repeat_en; end
                end
                2: begin
                    if (m_db[1]) m_mode = 0;
                    else if (!m_db[0]) m_mode = 3;
                    else begin m_age++; if (is_rep(m_age)) m_dn = repeat_en; end
                end
                default: if (m_db == 2'b11) m_mode = 0;
            endcase
            m_busy = (m_mode != 0);
            m_lvl = m_d2;
            m_d2  = m_d1;
            m_d1  = {key_minus, key_plus};
            m_db_new = m_db;
            for (int i = 0; i < 2; i++) begin
                if (m_lvl[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin m_db_new[i] = m_lvl[i]; m_run[i] = 0; end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_db_last = m_db;
            m_db      = m_db_new;
        end
    end

    // Per-cycle comparison against the model, and pulse-time logging.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cmd_up", int'(cmd_up), int'(m_up));
            chk("cmd_dn", int'(cmd_dn), int'(m_dn));
            chk("busy", int'(busy), int'(m_busy));
            chk("key_db", int'(key_db), int'(m_db));
            chk("one_cmd", int'(cmd_up && cmd_dn), 0);
            if (cmd_up === 1'b1) up_times.push_back(cyc - t0);
            if (cmd_dn === 1'b1) dn_times.push_back(cyc - t0);
        end
    end

    task automatic start_phase();
        @(negedge clk);
        up_times.delete();
        dn_times.delete();
        t0 = cyc;
    endtask

    task automatic at(input int k);
        while (cyc - t0 < k) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cmd_up", int'(cmd_up), 0);
        chk("rst_cmd_dn", int'(cmd_dn), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_key_db", int'(key_db), 3);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // clean press
        start_phase();
        key_plus = 1'b0;
        at(17); chk("clean_db_17", int'(key_db[0]), 1);
        at(18); chk("clean_db_18", int'(key_db[0]), 0);
        at(19); chk("clean_busy_19", int'(busy), 1);
        at(60); key_plus = 1'b1;
        at(78); chk("clean_busy_78", int'(busy), 1);
        at(79); chk("clean_busy_79", int'(busy), 0);
        at(90);
        exp_q = {19}; chk_q("clean_up", up_times, exp_q);
        exp_q = {};   chk_q("clean_dn", dn_times, exp_q);

        // bounce rejection
        start_phase();
        for (int i = 0; i < 10; i++) begin
            at(5 * i);
            key_minus = ~key_minus;
        end
        at(50); key_minus = 1'b0;
        at(90); key_minus = 1'b1;
        at(115);
        exp_q = {69}; chk_q("bounce_dn", dn_times, exp_q);
        exp_q = {};   chk_q("bounce_up", up_times, exp_q);

        // auto-repeat, then with repeat disabled
        start_phase();
        key_plus = 1'b0;
        at(219); key_plus = 1'b1;
        at(245);
        exp_q = {19, 119, 139, 159, 179, 199, 219}; chk_q("rep_up", up_times, exp_q);
        repeat_en = 1'b0;
        start_phase();
        key_plus = 1'b0;
        at(219); key_plus = 1'b1;
        at(245);
        exp_q = {19}; chk_q("norep_up", up_times, exp_q);
        repeat_en = 1'b1;

        // simultaneous press -> lock
        start_phase();
        key_plus = 1'b0; key_minus = 1'b0;
        at(25); chk("lock_busy_25", int'(busy), 1);
        at(40); key_plus = 1'b1;
        at(80); chk("lock_busy_80", int'(busy), 1);
        key_minus = 1'b1;
        at(120); chk("lock_busy_120", int'(busy), 0);
        exp_q = {}; chk_q("lock_up", up_times, exp_q);
        chk_q("lock_dn", dn_times, exp_q);
        start_phase();
        key_plus = 1'b0;
        at(40); key_plus = 1'b1;
        at(70);
        exp_q = {19}; chk_q("after_lock_up", up_times, exp_q);

        // cross-press while held
        start_phase();
        key_plus = 1'b0;
        at(69); key_minus = 1'b0;
        at(130); chk("cross_busy_130", int'(busy), 1);
        at(140); key_plus = 1'b1; key_minus = 1'b1;
        at(180); chk("cross_busy_180", int'(busy), 0);
        exp_q = {19}; chk_q("cross_up", up_times, exp_q);
        exp_q = {};   chk_q("cross_dn", dn_times, exp_q);

        // reset mid-hold
        start_phase();
        key_plus = 1'b0;
        at(129); rst_n = 1'b0;
        at(130);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_cmd_up", int'(cmd_up), 0);
        chk("mrst_key_db", int'(key_db), 3);
        at(132); rst_n = 1'b1;
        at(160); key_plus = 1'b1;
        at(200);
        exp_q = {19, 119, 151}; chk_q("mrst_up", up_times, exp_q);
        exp_q = {};             chk_q("mrst_dn", dn_times, exp_q);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
